ad9122_cfg_seq: RTL and testbench
=================================

AD9122_CFG_SEQ -- requirements
Module: ad9122_cfg_seq

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, meaning ARM write-buffer depth in 16-bit words (power of two, 2..16).
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 4096, meaning the maximum number of cycles to wait for CONFIG_END per word.
REQ-003 The block SHALL have parameter GAP_CYC, default 4, meaning the number of idle cycles enforced between consecutive words (1..255).
REQ-004 The block SHALL have port CLK, input, 1 bit, the single clock; one clock domain only.
REQ-005 The block SHALL have port RST, input, 1 bit; reset is synchronous and active-high.
REQ-006 The block SHALL have port ARM_WR, input, 1 bit, a one-cycle strobe that pushes ARM_DATA.
REQ-007 The block SHALL have port ARM_DATA, input, 16 bits, the register address/data word from ARM.
REQ-008 The block SHALL have port ARM_FULL, output, 1 bit, high when the FIFO holds FIFO_DEPTH words.
REQ-009 The block SHALL have port ERR_CLR, input, 1 bit, a strobe that clears the sticky OVF_ERR and TO_ERR flags.
REQ-010 The block SHALL have port CONFIG_EN, output, 1 bit, the request level to the SPI engine.
REQ-011 The block SHALL have port CONFIG_DATA, output, 16 bits, the word for the SPI engine; it is stable while CONFIG_EN=1.
REQ-012 The block SHALL have port CONFIG_END, input, 1 bit, the SPI engine's one-cycle completion pulse.
REQ-013 The block SHALL have port BUSY, output, 1 bit, high in any state other than IDLE or when the FIFO is non-empty.
REQ-014 The block SHALL have port INIT_DONE, output, 1 bit, high once the init table has completed (tied 1 when the table is compiled out).
REQ-015 The block SHALL have port OVF_ERR, output, 1 bit, a sticky flag indicating an ARM write was dropped.
REQ-016 The block SHALL have port TO_ERR, output, 1 bit, a sticky flag indicating a CONFIG_END timeout occurred.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE, GAP and INIT (INIT exists only with the macro; see Configuration).
REQ-018 In IDLE with the FIFO non-empty, the block SHALL pop the head word, load it into CONFIG_DATA, set CONFIG_EN=1 on the next cycle and enter ISSUE.
REQ-019 Latency from ARM_WR into an empty FIFO in IDLE to CONFIG_EN=1 SHALL be 2 cycles.
REQ-020 In ISSUE, CONFIG_EN SHALL be held at 1 and CONFIG_DATA held constant until CONFIG_END=1; CONFIG_EN SHALL be 0 on the following cycle, and the FSM SHALL then enter GAP.
REQ-021 In ISSUE, a cycle counter SHALL count from 0; if it reaches TIMEOUT_CYC-1 without CONFIG_END, the block SHALL drive CONFIG_EN=0, set TO_ERR, discard the word and enter GAP.
REQ-022 CONFIG_END coinciding with the timeout cycle SHALL count as success, with TO_ERR not set.
REQ-023 CONFIG_END received outside ISSUE SHALL be ignored.
REQ-024 GAP SHALL last exactly GAP_CYC cycles with CONFIG_EN=0, then return to IDLE (or INIT if table words remain).
REQ-025 The FIFO SHALL be first-in first-out, with wrap-around pointers and occupancy 0..FIFO_DEPTH.
REQ-026 An ARM_WR while full SHALL drop the word and set OVF_ERR, leaving FIFO contents unchanged.
REQ-027 An ARM_WR and a pop in the same cycle when full SHALL accept the write, with no overflow and occupancy unchanged.
REQ-028 ARM_WR SHALL be accepted in every state, including INIT, ISSUE and GAP.
REQ-029 ERR_CLR SHALL clear both sticky flags; an error event in the same cycle as ERR_CLR SHALL win, leaving the flag set.
REQ-030 CONFIG_DATA SHALL retain the last issued word after CONFIG_EN falls.

Reset
REQ-031 While RST=1 at a CLK edge, the block SHALL set CONFIG_EN=0, CONFIG_DATA=16'h0000, OVF_ERR=0, TO_ERR=0 and FIFO empty (ARM_FULL=0), with all counters cleared.
REQ-032 Reset SHALL set the FSM to INIT with the table index at 0 when the macro is defined, otherwise to IDLE.
REQ-033 Reset SHALL set INIT_DONE=0 when the macro is defined, otherwise INIT_DONE=1.
REQ-034 RST asserted mid-transfer SHALL abort it immediately: CONFIG_EN=0 on the next cycle, and any buffered words are flushed.

Configuration
REQ-035 With macro AD9122_INIT_TABLE_EN defined, after reset the block SHALL issue the 15-word table in order before serving the FIFO.
REQ-036 The table SHALL be 0020,0000,1048,1600,1705,1BE0,1C01,1D00,1E01,1803,1800,40FF,4103,44FF,4503 (hex).
REQ-037 Each table word SHALL use the same ISSUE/GAP/timeout rules as FIFO words, and INIT_DONE SHALL rise on the cycle after the GAP following word 15.
REQ-038 A table word that times out SHALL set TO_ERR, after which the sequence SHALL continue with the next word.
REQ-039 With AD9122_INIT_TABLE_EN undefined, no table logic SHALL exist, and the block SHALL start in IDLE, serving ARM words only.

Verification
REQ-040 A bench SHALL cover: macro off, single ARM_WR 16'h1803, END returned 10 cycles after EN -> CONFIG_EN high 2 cycles after WR, CONFIG_DATA=1803 throughout, EN low the cycle after END, and no new EN for 4 cycles.
REQ-041 A bench SHALL cover: 5 back-to-back ARM_WR (1..5) with FIFO_DEPTH=4 while SPI stalls -> ARM_FULL=1, OVF_ERR=1, issued words 1,2,3,4 only, in order.
REQ-042 A bench SHALL cover: TIMEOUT_CYC=16 with END never returned -> EN falls after 16 cycles, TO_ERR=1, next FIFO word issued; then ERR_CLR -> TO_ERR=0.
REQ-043 A bench SHALL cover: macro on, with SPI model auto-END after 3 cycles -> 15 table words in the listed order, then INIT_DONE=1, and ARM words written during init issued afterward.
REQ-044 A bench SHALL cover: RST pulsed during ISSUE of word 0x40FF with 2 words buffered -> EN=0 next cycle, FIFO empty, and table restarts at 0020 (macro on).
REQ-045 A bench SHALL cover: END arriving on the timeout cycle, and ARM_WR plus pop when full -> no TO_ERR, no OVF_ERR.

Source files
------------

// File: rtl/ad9122_cfg_seq.sv
// ad9122_cfg_seq: buffers ARM register words and hands them one at a time to the AD9122 SPI engine.
// Define AD9122_INIT_TABLE_EN to replay a fixed power-up register table before serving the FIFO.
module ad9122_cfg_seq #(
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned TIMEOUT_CYC = 4096,
   parameter int unsigned GAP_CYC     = 4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        ARM_WR,
   input  logic [15:0] ARM_DATA,
   output logic        ARM_FULL,
   input  logic        ERR_CLR,
   output logic        CONFIG_EN,
   output logic [15:0] CONFIG_DATA,
   input  logic        CONFIG_END,
   output logic        BUSY,
   output logic        INIT_DONE,
   output logic        OVF_ERR,
   output logic        TO_ERR
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);
   localparam logic [7:0]    GAP_LAST = 8'(GAP_CYC - 1);

`ifdef AD9122_INIT_TABLE_EN
   typedef enum logic [1:0] {StIdle, StIssue, StGap, StInit} state_e;

   function automatic logic [15:0] init_word(input logic [3:0] idx);
      case (idx)
         4'd0:    init_word = 16'h0020;
         4'd1:    init_word = 16'h0000;
         4'd2:    init_word = 16'h1048;
         4'd3:    init_word = 16'h1600;
         4'd4:    init_word = 16'h1705;
         4'd5:    init_word = 16'h1BE0;
         4'd6:    init_word = 16'h1C01;
         4'd7:    init_word = 16'h1D00;
         4'd8:    init_word = 16'h1E01;
         4'd9:    init_word = 16'h1803;
         4'd10:   init_word = 16'h1800;
         4'd11:   init_word = 16'h40FF;
         4'd12:   init_word = 16'h4103;
         4'd13:   init_word = 16'h44FF;
         4'd14:   init_word = 16'h4503;
         default: init_word = 16'h0000;
      endcase
   endfunction

   logic [3:0] idx_q, idx_d;
   logic       init_done_q, init_done_d;
`else
   typedef enum logic [1:0] {StIdle, StIssue, StGap} state_e;
`endif

   state_e        state_q, state_d;
   logic [15:0]   mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] cnt_q;
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic [7:0]    gap_cnt_q, gap_cnt_d;
   logic          en_q, en_d;
   logic [15:0]   data_q, data_d;
   logic          ovf_q, to_q;
   logic          pop, push, ovf_set, to_set;

   // A write into a full FIFO still lands when the FSM pops in the same cycle.
   assign ARM_FULL = (cnt_q == FULL_CNT);
   assign push     = ARM_WR && (!ARM_FULL || pop);
   assign ovf_set  = ARM_WR && ARM_FULL && !pop;

   always_ff @(posedge CLK) begin
      if (push) begin
         mem_q[wr_ptr_q] <= ARM_DATA;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         if (push && !pop)      cnt_q <= cnt_q + CW'(1);
         else if (pop && !push) cnt_q <= cnt_q - CW'(1);
      end
   end

   always_comb begin
      state_d   = state_q;
      to_cnt_d  = to_cnt_q;
      gap_cnt_d = gap_cnt_q;
      en_d      = en_q;
      data_d    = data_q;
      pop       = 1'b0;
      to_set    = 1'b0;
`ifdef AD9122_INIT_TABLE_EN
      idx_d       = idx_q;
      init_done_d = init_done_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (cnt_q != '0) begin
               pop      = 1'b1;
               data_d   = mem_q[rd_ptr_q];
               en_d     = 1'b1;
               to_cnt_d = '0;
               state_d  = StIssue;
            end
         end
         StIssue: begin
            // END on the final timeout cycle is still a clean completion.
            if (CONFIG_END) begin
               en_d      = 1'b0;
               gap_cnt_d = '0;
               state_d   = StGap;
            end else if (to_cnt_q == TO_LAST) begin
               en_d      = 1'b0;
               to_set    = 1'b1;
               gap_cnt_d = '0;
               state_d   = StGap;
            end else begin
               to_cnt_d = to_cnt_q + TW'(1);
            end
         end
         StGap: begin
            if (gap_cnt_q == GAP_LAST) begin
`ifdef AD9122_INIT_TABLE_EN
               if (idx_q == 4'd15) begin
                  init_done_d = 1'b1;
                  state_d     = StIdle;
               end else begin
                  state_d = StInit;
               end
`else
               state_d = StIdle;
`endif
            end else begin
               gap_cnt_d = gap_cnt_q + 8'd1;
            end
         end
`ifdef AD9122_INIT_TABLE_EN
         StInit: begin
            data_d   = init_word(idx_q);
            en_d     = 1'b1;
            to_cnt_d = '0;
            idx_d    = idx_q + 4'd1;
            state_d  = StIssue;
         end
`endif
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
`ifdef AD9122_INIT_TABLE_EN
         state_q     <= StInit;
         idx_q       <= '0;
         init_done_q <= 1'b0;
`else
         state_q     <= StIdle;
`endif
         to_cnt_q  <= '0;
         gap_cnt_q <= '0;
         en_q      <= 1'b0;
         data_q    <= 16'h0000;
         ovf_q     <= 1'b0;
         to_q      <= 1'b0;
      end else begin
`ifdef AD9122_INIT_TABLE_EN
         idx_q       <= idx_d;
         init_done_q <= init_done_d;
`endif
         state_q   <= state_d;
         to_cnt_q  <= to_cnt_d;
         gap_cnt_q <= gap_cnt_d;
         en_q      <= en_d;
         data_q    <= data_d;
         // A new error in the clearing cycle keeps the flag set.
         ovf_q     <= ovf_set ? 1'b1 : (ERR_CLR ? 1'b0 : ovf_q);
         to_q      <= to_set  ? 1'b1 : (ERR_CLR ? 1'b0 : to_q);
      end
   end

   assign CONFIG_EN   = en_q;
   assign CONFIG_DATA = data_q;
   assign OVF_ERR     = ovf_q;
   assign TO_ERR      = to_q;
   assign BUSY        = (state_q != StIdle) || (cnt_q != '0);
`ifdef AD9122_INIT_TABLE_EN
   assign INIT_DONE   = init_done_q;
`else
   assign INIT_DONE   = 1'b1;
`endif

endmodule

// File: tb/tb_ad9122_cfg_seq.sv
// tb_ad9122_cfg_seq: self-checking bench for ad9122_cfg_seq with an SPI responder model.
// Table sequences run only when AD9122_INIT_TABLE_EN is defined.
module tb_ad9122_cfg_seq;

   localparam int unsigned DEPTH  = 4;
   localparam int unsigned TO_CYC = 16;
   localparam int unsigned GAP    = 4;
   localparam int          RAND_N = 30;

   logic        CLK;
   logic        RST;
   logic        ARM_WR;
   logic [15:0] ARM_DATA;
   logic        ARM_FULL;
   logic        ERR_CLR;
   logic        CONFIG_EN;
   logic [15:0] CONFIG_DATA;
   logic        CONFIG_END;
   logic        BUSY;
   logic        INIT_DONE;
   logic        OVF_ERR;
   logic        TO_ERR;

   ad9122_cfg_seq #(
      .FIFO_DEPTH (DEPTH),
      .TIMEOUT_CYC(TO_CYC),
      .GAP_CYC    (GAP)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .ARM_WR     (ARM_WR),
      .ARM_DATA   (ARM_DATA),
      .ARM_FULL   (ARM_FULL),
      .ERR_CLR    (ERR_CLR),
      .CONFIG_EN  (CONFIG_EN),
      .CONFIG_DATA(CONFIG_DATA),
      .CONFIG_END (CONFIG_END),
      .BUSY       (BUSY),
      .INIT_DONE  (INIT_DONE),
      .OVF_ERR    (OVF_ERR),
      .TO_ERR     (TO_ERR)
   );

   typedef struct {
      logic [15:0] data;
      int          dly;
      int          exp_len;
      bit          exp_to;
   } vec_t;

   int          errors;
   int          checks;
   int          stab_bad;
   int          def_dly;
   logic        force_end;
   logic [15:0] tbl [15];
   logic [15:0] iss_q [$];
   int          len_q [$];
   int          gap_q [$];
   int          dly_q [$];
   logic [15:0] exp_q [$];
   int          explen_q [$];
   vec_t        vecs [5];

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // SPI engine model: END pulses after the per-word delay (0 = never); also logs every issue.
   initial begin : spi_model
      int   en_cnt;
      int   cur_dly;
      int   low_cnt;
      logic en_prev;
      logic [15:0] held;
      en_cnt = 0; cur_dly = 0; low_cnt = 0; en_prev = 1'b0; held = 16'h0;
      CONFIG_END = 1'b0;
      forever begin
         @(negedge CLK);
         CONFIG_END = 1'b0;
         if (CONFIG_EN) begin
            if (!en_prev) begin
               cur_dly = (dly_q.size() > 0) ? dly_q.pop_front() : def_dly;
               en_cnt  = 0;
               held    = CONFIG_DATA;
               iss_q.push_back(CONFIG_DATA);
               gap_q.push_back(low_cnt);
            end else if (CONFIG_DATA !== held) begin
               stab_bad++;
            end
            en_cnt++;
            if (cur_dly > 0 && en_cnt == cur_dly) CONFIG_END = 1'b1;
         end else begin
            if (en_prev) begin
               len_q.push_back(en_cnt);
               low_cnt = 0;
            end
            low_cnt++;
         end
         if (force_end) CONFIG_END = 1'b1;
         en_prev = CONFIG_EN;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic clear_logs();
      iss_q.delete(); len_q.delete(); gap_q.delete(); dly_q.delete();
   endtask

   task automatic arm_write(input logic [15:0] d);
      ARM_WR = 1'b1; ARM_DATA = d;
      @(negedge CLK);
      ARM_WR = 1'b0;
   endtask

   task automatic wait_len(input int n, input int bound, input string name);
      int c = 0;
      while (len_q.size() < n && c < bound) begin @(negedge CLK); c++; end
      chk(name, 32'(len_q.size() >= n), 32'd1);
   endtask

   task automatic wait_en(input logic val, input int bound, input string name);
      int c = 0;
      while (CONFIG_EN !== val && c < bound) begin @(negedge CLK); c++; end
      chk(name, CONFIG_EN, val);
   endtask

   task automatic do_reset();
      RST = 1'b1; ARM_WR = 1'b0; ERR_CLR = 1'b0;
      @(negedge CLK); @(negedge CLK);
      chk("rst_en", CONFIG_EN, 0);
      chk("rst_data", CONFIG_DATA, 16'h0000);
      chk("rst_ovf", OVF_ERR, 0);
      chk("rst_to", TO_ERR, 0);
      chk("rst_full", ARM_FULL, 0);
`ifdef AD9122_INIT_TABLE_EN
      chk("rst_init_done", INIT_DONE, 0);
      chk("rst_busy", BUSY, 1);
`else
      chk("rst_init_done", INIT_DONE, 1);
      chk("rst_busy", BUSY, 0);
`endif
      clear_logs();
      RST = 1'b0;
   endtask

`ifdef AD9122_INIT_TABLE_EN
   task automatic wait_init(input string name);
      int c = 0;
      while (!INIT_DONE && c < 400) begin @(negedge CLK); c++; end
      chk(name, INIT_DONE, 1);
   endtask

   task automatic init_phase();
      arm_write(16'hA001);
      arm_write(16'hA002);
      chk("init_done_early", INIT_DONE, 0);
      wait_init("init_done");
      chk("init_count", iss_q.size(), 15);
      for (int i = 0; i < 15; i++)
         if (i < iss_q.size()) chk($sformatf("init_word%0d", i), iss_q[i], tbl[i]);
      wait_len(17, 100, "init_arm_wait");
      if (iss_q.size() >= 17) begin
         chk("init_arm0", iss_q[15], 16'hA001);
         chk("init_arm1", iss_q[16], 16'hA002);
      end
      repeat (10) @(negedge CLK);
      // Reset in the middle of the table with two ARM words buffered.
      RST = 1'b1;
      @(negedge CLK); @(negedge CLK);
      clear_logs();
      RST = 1'b0;
      arm_write(16'hB001);
      arm_write(16'hB002);
      begin
         int c = 0;
         while (!(CONFIG_EN && CONFIG_DATA == 16'h40FF) && c < 400) begin @(negedge CLK); c++; end
      end
      chk("w40ff_seen", CONFIG_DATA, 16'h40FF);
      RST = 1'b1;
      @(negedge CLK);
      chk("mid_rst_en", CONFIG_EN, 0);
      chk("mid_rst_full", ARM_FULL, 0);
      chk("mid_rst_done", INIT_DONE, 0);
      @(negedge CLK);
      clear_logs();
      RST = 1'b0;
      wait_init("restart_done");
      repeat (30) @(negedge CLK);
      chk("restart_count", iss_q.size(), 15);
      if (iss_q.size() > 0) chk("restart_first", iss_q[0], 16'h0020);
      if (iss_q.size() == 15) chk("restart_last", iss_q[14], 16'h4503);
      clear_logs();
   endtask
`endif

   initial begin
      int          bad;
      int          n;
      int          guard;
      bit          exp_to;
      logic [15:0] d;
      int          dl;
      errors = 0; checks = 0; stab_bad = 0; def_dly = 3; force_end = 1'b0;
      RST = 1'b1; ARM_WR = 1'b0; ARM_DATA = 16'h0; ERR_CLR = 1'b0;
      tbl = '{16'h0020, 16'h0000, 16'h1048, 16'h1600, 16'h1705, 16'h1BE0, 16'h1C01, 16'h1D00,
              16'h1E01, 16'h1803, 16'h1800, 16'h40FF, 16'h4103, 16'h44FF, 16'h4503};
      vecs[0] = '{16'h1803, 10, 10, 1'b0};
      vecs[1] = '{16'hABCD, 1, 1, 1'b0};
      vecs[2] = '{16'h5A5A, 16, 16, 1'b0};
      vecs[3] = '{16'h0F0F, 0, 16, 1'b1};
      vecs[4] = '{16'hFFFF, 17, 16, 1'b1};

      do_reset();
`ifdef AD9122_INIT_TABLE_EN
      init_phase();
`endif

      // Single words: latency, hold length, timeout and retained data.
      for (int v = 0; v < 5; v++) begin
         clear_logs();
         dly_q.push_back(vecs[v].dly);
         ARM_WR = 1'b1; ARM_DATA = vecs[v].data;
         @(negedge CLK);
         ARM_WR = 1'b0;
         chk($sformatf("v%0d_lat1_en", v), CONFIG_EN, 0);
         @(negedge CLK);
         chk($sformatf("v%0d_lat2_en", v), CONFIG_EN, 1);
         chk($sformatf("v%0d_data", v), CONFIG_DATA, vecs[v].data);
         wait_len(1, 40, $sformatf("v%0d_done", v));
         if (len_q.size() > 0) chk($sformatf("v%0d_len", v), len_q[0], vecs[v].exp_len);
         if (iss_q.size() > 0) chk($sformatf("v%0d_issued", v), iss_q[0], vecs[v].data);
         chk($sformatf("v%0d_to_err", v), TO_ERR, vecs[v].exp_to);
         chk($sformatf("v%0d_retain", v), CONFIG_DATA, vecs[v].data);
         bad = 0;
         repeat (GAP + 2) begin @(negedge CLK); if (CONFIG_EN) bad++; end
         chk($sformatf("v%0d_quiet", v), bad, 0);
         ERR_CLR = 1'b1;
         @(negedge CLK);
         ERR_CLR = 1'b0;
         chk($sformatf("v%0d_clr", v), TO_ERR, 0);
      end

      // Overflow: burst of five while a long word holds the engine; clear collides with the drop.
      clear_logs();
      dly_q = '{15, 3, 3, 3, 3};
      arm_write(16'hEEEE);
      wait_en(1'b1, 5, "ovf_dummy_en");
      for (int i = 1; i <= 5; i++) begin
         ARM_WR = 1'b1; ARM_DATA = 16'(i);
         ERR_CLR = (i == 5);
         @(negedge CLK);
      end
      ARM_WR = 1'b0; ERR_CLR = 1'b0;
      chk("ovf_full", ARM_FULL, 1);
      chk("ovf_err", OVF_ERR, 1);
      wait_len(5, 200, "ovf_drain");
      repeat (20) @(negedge CLK);
      chk("ovf_count", iss_q.size(), 5);
      if (iss_q.size() == 5) begin
         chk("ovf_w0", iss_q[0], 16'hEEEE);
         for (int i = 1; i < 5; i++) begin
            chk($sformatf("ovf_w%0d", i), iss_q[i], 16'(i));
            chk($sformatf("ovf_gap%0d", i), gap_q[i], GAP + 1);
         end
      end
      chk("ovf_no_to", TO_ERR, 0);
      ERR_CLR = 1'b1; @(negedge CLK); ERR_CLR = 1'b0;
      chk("ovf_clr", OVF_ERR, 0);

      // Write while full in the same cycle the FSM pops.
      clear_logs();
      dly_q = '{8, 3, 3, 3, 3, 3};
      arm_write(16'hD000);
      wait_en(1'b1, 5, "wp_dummy_en");
      for (int i = 1; i <= 4; i++) begin
         ARM_WR = 1'b1; ARM_DATA = 16'hD000 + 16'(i);
         @(negedge CLK);
      end
      ARM_WR = 1'b0;
      chk("wp_full_pre", ARM_FULL, 1);
      wait_en(1'b0, 20, "wp_dummy_fall");
      repeat (GAP) @(negedge CLK);
      ARM_WR = 1'b1; ARM_DATA = 16'h7777;
      @(negedge CLK);
      ARM_WR = 1'b0;
      chk("wp_full_post", ARM_FULL, 1);
      chk("wp_no_ovf", OVF_ERR, 0);
      chk("wp_en", CONFIG_EN, 1);
      wait_len(6, 200, "wp_drain");
      repeat (10) @(negedge CLK);
      chk("wp_count", iss_q.size(), 6);
      if (iss_q.size() == 6) chk("wp_last", iss_q[5], 16'h7777);
      chk("wp_no_to", TO_ERR, 0);

      // Clear colliding with a timeout leaves TO_ERR set.
      clear_logs();
      dly_q.push_back(0);
      arm_write(16'hC0C0);
      wait_en(1'b1, 5, "tc_en");
      repeat (TO_CYC - 1) @(negedge CLK);
      ERR_CLR = 1'b1;
      @(negedge CLK);
      ERR_CLR = 1'b0;
      chk("tc_en_fall", CONFIG_EN, 0);
      chk("tc_to_kept", TO_ERR, 1);
      ERR_CLR = 1'b1; @(negedge CLK); ERR_CLR = 1'b0;
      chk("tc_clr", TO_ERR, 0);
      repeat (GAP + 2) @(negedge CLK);

      // Stray END outside ISSUE must not disturb the next word.
      clear_logs();
      force_end = 1'b1; @(negedge CLK); force_end = 1'b0;
      chk("stray_en", CONFIG_EN, 0);
      dly_q.push_back(5);
      arm_write(16'h0D0D);
      wait_len(1, 40, "stray_done");
      if (len_q.size() > 0) chk("stray_len", len_q[0], 5);
      chk("stray_to", TO_ERR, 0);
      repeat (GAP + 2) @(negedge CLK);

`ifndef AD9122_INIT_TABLE_EN
      // Reset mid-transfer flushes buffered words.
      clear_logs();
      dly_q.push_back(0);
      arm_write(16'h1111); arm_write(16'h2222); arm_write(16'h3333);
      wait_en(1'b1, 5, "mr_en");
      repeat (3) @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      chk("mr_en_low", CONFIG_EN, 0);
      chk("mr_data", CONFIG_DATA, 16'h0000);
      chk("mr_busy", BUSY, 0);
      chk("mr_full", ARM_FULL, 0);
      RST = 1'b0;
      repeat (30) @(negedge CLK);
      chk("mr_flushed", iss_q.size(), 1);
      clear_logs();
`endif

      // Random traffic against an in-order, min(delay, timeout) reference.
      clear_logs(); exp_q.delete(); explen_q.delete();
      exp_to = 1'b0; n = 0; guard = 0;
      while (n < RAND_N && guard < 3000) begin
         if (!ARM_FULL && $urandom_range(0, 1) == 1) begin
            d  = 16'($urandom());
            dl = int'($urandom_range(0, 20));
            exp_q.push_back(d);
            dly_q.push_back(dl);
            explen_q.push_back((dl == 0 || dl > TO_CYC) ? TO_CYC : dl);
            if (dl == 0 || dl > TO_CYC) exp_to = 1'b1;
            ARM_WR = 1'b1; ARM_DATA = d;
            n++;
         end else begin
            ARM_WR = 1'b0;
         end
         @(negedge CLK);
         guard++;
      end
      ARM_WR = 1'b0;
      wait_len(RAND_N, 2000, "rand_drain");
      repeat (5) @(negedge CLK);
      chk("rand_count", iss_q.size(), RAND_N);
      for (int i = 0; i < RAND_N; i++) begin
         if (i < iss_q.size()) chk($sformatf("rand_data%0d", i), iss_q[i], exp_q[i]);
         if (i < len_q.size()) chk($sformatf("rand_len%0d", i), len_q[i], explen_q[i]);
      end
      bad = 0;
      for (int i = 1; i < gap_q.size(); i++) if (gap_q[i] < GAP + 1) bad++;
      chk("rand_gaps", bad, 0);
      chk("rand_to", TO_ERR, exp_to);
      chk("rand_ovf", OVF_ERR, 0);
      chk("data_stable", stab_bad, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
